// File: rtl/projectile_pool_pkg.sv
// projectile_pool_pkg: shared headings, slot states and coordinate type.
// Rev 1.0
`default_nettype none

package projectile_pool_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    LEFT  = 2'b01,
    DOWN  = 2'b10,
    RIGHT = 2'b11
  } heading_t;

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } slot_state_t;

  typedef logic [9:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/projectile_slot.sv
// projectile_slot: one projectile -- motion along its heading, bounds retire, target strike.
// Rev 1.0
`default_nettype none

module projectile_slot
  import projectile_pool_pkg::*;
#(
  parameter int STEP  = 8,
  parameter int X_MIN = 1,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 1,
  parameter int Y_MAX = 479
) (
  input  logic     frame_clk,
  input  logic     Reset,
  input  logic     launch,
  input  heading_t launch_dir,
  input  coord_t   launch_x,
  input  coord_t   launch_y,
  input  coord_t   other_x,
  input  coord_t   other_y,
  input  coord_t   tank_size,
  output coord_t   x,
  output coord_t   y,
  output logic     active,
  output logic     strike
);

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

  slot_state_t       state;
  heading_t          dir;
  logic signed [10:0] dx, dy, nx, ny;
  logic [10:0]       half, ux, uy, ox, oy;
  logic              out_of_bounds, hit_x, hit_y;

  always_comb begin
    dx = '0;
    dy = '0;
    case (dir)
      UP:    dy = -STEP_S;
      LEFT:  dx = -STEP_S;
      DOWN:  dy = STEP_S;
      RIGHT: dx = STEP_S;
    endcase
    // Next position in signed 11 bits so stepping past 0 reads as negative, not a wrap.
    nx = $signed({1'b0, x}) + dx;
    ny = $signed({1'b0, y}) + dy;
    out_of_bounds = (nx < XMIN_S) || (nx > XMAX_S) || (ny < YMIN_S) || (ny > YMAX_S);

    half  = 11'(tank_size >> 1);
    ux    = {1'b0, x};
    uy    = {1'b0, y};
    ox    = {1'b0, other_x};
    oy    = {1'b0, other_y};
    hit_x = (ux + half >= ox) && (ux <= ox + half);
    hit_y = (uy + half >= oy) && (uy <= oy + half);
    strike = (state == FLY) && hit_x && hit_y;
  end

  assign active = (state == FLY);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
      dir   <= UP;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state <= FLY;
            dir   <= launch_dir;
            x     <= launch_x;
            y     <= launch_y;
          end
        end
        FLY: begin
          // A strike outranks leaving the field; both retire the slot.
          if (strike || out_of_bounds) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
          end else begin
            x <= nx[9:0];
            y <= ny[9:0];
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/projectile_pool.sv
// projectile_pool: fire-edge detect, lowest-idle slot allocation, cooldown and hit tally.
// Rev 1.0
`default_nettype none

module projectile_pool
  import projectile_pool_pkg::*;
#(
  parameter int          NUM_SHOTS = 4,
  parameter int          STEP      = 8,
  parameter int          COOLDOWN  = 6,
  parameter logic [15:0] FIRE_CODE = 16'h0009,
  parameter int          X_MIN     = 1,
  parameter int          X_MAX     = 639,
  parameter int          Y_MIN     = 1,
  parameter int          Y_MAX     = 479
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [15:0]             keycode,
  input  logic [1:0]              tankdir,
  input  logic [9:0]              parentX,
  input  logic [9:0]              parentY,
  input  logic [9:0]              otherX,
  input  logic [9:0]              otherY,
  input  logic [9:0]              tank_size,
  output logic [NUM_SHOTS*10-1:0] shot_x,
  output logic [NUM_SHOTS*10-1:0] shot_y,
  output logic [NUM_SHOTS-1:0]    shot_active,
  output logic                    ball_fire,
  output logic                    hit,
  output logic [7:0]              hit_count
);

  localparam logic [5:0]           CD_LOAD = 6'(COOLDOWN);
  localparam logic [NUM_SHOTS-1:0] ONE     = NUM_SHOTS'(1);

  logic                 fire_now, fire_prev, fire_req, accept;
  logic [5:0]           cooldown;
  logic [NUM_SHOTS-1:0] idle, grant, launch_vec, strike;

  assign fire_now = (keycode == FIRE_CODE);
  assign fire_req = fire_now && !fire_prev;

  // Idle status is taken from registered state, so a slot retiring this
  // cycle still counts as busy and cannot be re-claimed until the next one.
  assign idle       = ~shot_active;
  assign grant      = idle & (~idle + ONE);
  assign accept     = fire_req && (cooldown == 6'd0) && (|idle);
  assign launch_vec = accept ? grant : '0;

  generate
    for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
      projectile_slot #(
        .STEP  (STEP),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX),
        .Y_MIN (Y_MIN),
        .Y_MAX (Y_MAX)
      ) u_slot (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .launch     (launch_vec[i]),
        .launch_dir (heading_t'(tankdir)),
        .launch_x   (parentX),
        .launch_y   (parentY),
        .other_x    (otherX),
        .other_y    (otherY),
        .tank_size  (tank_size),
        .x          (shot_x[10*i +: 10]),
        .y          (shot_y[10*i +: 10]),
        .active     (shot_active[i]),
        .strike     (strike[i])
      );
    end
  endgenerate

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      fire_prev <= 1'b0;
      cooldown  <= '0;
      ball_fire <= 1'b0;
      hit       <= 1'b0;
      hit_count <= '0;
    end else begin
      fire_prev <= fire_now;
      ball_fire <= accept;
      hit       <= |strike;
      if ((|strike) && (hit_count != 8'hFF))
        hit_count <= hit_count + 8'd1;
      if (accept)
        cooldown <= CD_LOAD;
      else if (cooldown != 6'd0)
        cooldown <= cooldown - 6'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_projectile_pool.sv
// tb_projectile_pool: directed checks of launch, motion, cooldown, retire, hit and reset.
// Rev 1.0
`default_nettype none

module tb_projectile_pool;

  localparam logic [15:0] FIRE = 16'h0009;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [15:0] keycode   = '0;
  logic [1:0]  tankdir   = '0;
  logic [9:0]  parentX = '0, parentY = '0, otherX = '0, otherY = '0, tank_size = '0;

  logic [39:0] a_x, a_y, b_x, b_y;
  logic [3:0]  a_act, b_act;
  logic        a_fire, b_fire, a_hit, b_hit;
  logic [7:0]  a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 frame_clk = ~frame_clk;

  projectile_pool dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .tankdir(tankdir),
    .parentX(parentX), .parentY(parentY), .otherX(otherX), .otherY(otherY),
    .tank_size(tank_size), .shot_x(a_x), .shot_y(a_y), .shot_active(a_act),
    .ball_fire(a_fire), .hit(a_hit), .hit_count(a_cnt)
  );

  projectile_pool #(.COOLDOWN(0)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .tankdir(tankdir),
    .parentX(parentX), .parentY(parentY), .otherX(otherX), .otherY(otherY),
    .tank_size(tank_size), .shot_x(b_x), .shot_y(b_y), .shot_active(b_act),
    .ball_fire(b_fire), .hit(b_hit), .hit_count(b_cnt)
  );

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    keycode = '0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (a_act !== 4'b0000) begin bad++; $display("FAIL reset_active got=%b want=0000", a_act); end
    total++; if (a_x !== 40'd0 || a_y !== 40'd0) begin bad++; $display("FAIL reset_pos got=%h/%h want=0", a_x, a_y); end
    total++; if (a_fire !== 1'b0 || a_hit !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", a_fire, a_hit); end
    total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", a_cnt); end
  endtask

  task automatic test_launch_right();
    int pulses;
    do_reset();
    tankdir = 2'b11; parentX = 10'd100; parentY = 10'd200;
    keycode = FIRE;
    tick();
    total++; if (a_fire !== 1'b1 || a_act !== 4'b0001) begin bad++; $display("FAIL launch_fire got=%b/%b want=1/0001", a_fire, a_act); end
    total++; if (a_x[9:0] !== 10'd100 || a_y[9:0] !== 10'd200) begin bad++; $display("FAIL launch_pos got=%0d,%0d want=100,200", a_x[9:0], a_y[9:0]); end
    pulses = 0;
    tick(); pulses += int'(a_fire);
    total++; if (a_x[9:0] !== 10'd108) begin bad++; $display("FAIL step1_x got=%0d want=108", a_x[9:0]); end
    tick(); pulses += int'(a_fire);
    total++; if (a_x[9:0] !== 10'd116 || a_y[9:0] !== 10'd200) begin bad++; $display("FAIL step2_pos got=%0d,%0d want=116,200", a_x[9:0], a_y[9:0]); end
    tick(); pulses += int'(a_fire);
    tick(); pulses += int'(a_fire);
    total++; if (pulses !== 0) begin bad++; $display("FAIL held_key_extra_fires got=%0d want=0", pulses); end
    keycode = '0;
  endtask

  task automatic test_cooldown();
    logic [9:0] press_tbl;
    logic [9:0] fire_tbl;
    press_tbl = 10'b0010001001;  // frames 0, 3, 7
    fire_tbl  = 10'b0010000001;  // frames 0, 7
    do_reset();
    tankdir = 2'b11; parentX = 10'd100; parentY = 10'd200;
    for (int f = 0; f < 10; f++) begin
      keycode = press_tbl[f] ? FIRE : 16'h0000;
      tick();
      total++;
      if (a_fire !== fire_tbl[f]) begin bad++; $display("FAIL cooldown_frame%0d got=%b want=%b", f, a_fire, fire_tbl[f]); end
    end
    keycode = '0;
  endtask

  task automatic test_retire_up();
    do_reset();
    tankdir = 2'b00; parentX = 10'd50; parentY = 10'd20;
    keycode = FIRE;
    tick();
    keycode = '0;
    total++; if (a_y[9:0] !== 10'd20) begin bad++; $display("FAIL up_y0 got=%0d want=20", a_y[9:0]); end
    tick();
    total++; if (a_y[9:0] !== 10'd12 || a_x[9:0] !== 10'd50) begin bad++; $display("FAIL up_y1 got=%0d,%0d want=50,12", a_x[9:0], a_y[9:0]); end
    tick();
    total++; if (a_y[9:0] !== 10'd4) begin bad++; $display("FAIL up_y2 got=%0d want=4", a_y[9:0]); end
    tick();
    total++; if (a_act[0] !== 1'b0 || a_y[9:0] !== 10'd0 || a_x[9:0] !== 10'd0) begin bad++; $display("FAIL up_retire got=%b,%0d,%0d want=0,0,0", a_act[0], a_x[9:0], a_y[9:0]); end
  endtask

  task automatic test_hit();
    logic [9:0] xs [4];
    xs = '{10'd268, 10'd276, 10'd284, 10'd292};
    do_reset();
    otherX = 10'd300; otherY = 10'd200; tank_size = 10'd20;
    tankdir = 2'b11; parentX = 10'd260; parentY = 10'd200;
    keycode = FIRE;
    tick();
    keycode = '0;
    total++; if (a_x[9:0] !== 10'd260 || a_hit !== 1'b0) begin bad++; $display("FAIL hit_launch got=%0d,%b want=260,0", a_x[9:0], a_hit); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (a_x[9:0] !== xs[k] || a_hit !== 1'b0 || a_act[0] !== 1'b1) begin
        bad++; $display("FAIL hit_approach%0d got=%0d,%b,%b want=%0d,0,1", k, a_x[9:0], a_hit, a_act[0], xs[k]);
      end
    end
    tick();
    total++; if (a_hit !== 1'b1 || a_act[0] !== 1'b0 || a_cnt !== 8'd1) begin bad++; $display("FAIL hit_strike got=%b,%b,%0d want=1,0,1", a_hit, a_act[0], a_cnt); end
    tick();
    total++; if (a_hit !== 1'b0 || a_cnt !== 8'd1) begin bad++; $display("FAIL hit_after got=%b,%0d want=0,1", a_hit, a_cnt); end
    otherX = '0; otherY = '0; tank_size = '0;
  endtask

  task automatic test_reset_midflight();
    int pulses;
    tankdir = 2'b11; parentX = 10'd100; parentY = 10'd200;
    keycode = FIRE; tick();
    keycode = '0;   tick();
    keycode = FIRE; tick();
    total++; if (b_act !== 4'b0011) begin bad++; $display("FAIL midflight_pre got=%b want=0011", b_act); end
    Reset = 1'b1;
    tick();
    total++; if (b_act !== 4'b0000 || b_x !== 40'd0 || b_y !== 40'd0 || b_fire !== 1'b0) begin bad++; $display("FAIL midflight_reset got=%b,%h,%h,%b want=0", b_act, b_x, b_y, b_fire); end
    total++; if (a_cnt !== 8'd0 || a_hit !== 1'b0) begin bad++; $display("FAIL midflight_count got=%0d,%b want=0,0", a_cnt, a_hit); end
    tick();
    Reset = 1'b0;
    tick();
    total++; if (b_fire !== 1'b1 || a_fire !== 1'b1 || b_act !== 4'b0001) begin bad++; $display("FAIL release_fire got=%b,%b,%b want=1,1,0001", b_fire, a_fire, b_act); end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin tick(); pulses += int'(b_fire); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL release_extra got=%0d want=0", pulses); end
    keycode = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    tankdir = 2'b11; parentX = 10'd100; parentY = 10'd200; keycode = FIRE; tick();
    total++; if (b_fire !== 1'b1 || b_act !== 4'b0001) begin bad++; $display("FAIL pool_p1 got=%b,%b want=1,0001", b_fire, b_act); end
    keycode = '0; tick();
    tankdir = 2'b00; parentX = 10'd50; parentY = 10'd44; keycode = FIRE; tick();
    total++; if (b_fire !== 1'b1 || b_act !== 4'b0011 || b_y[19:10] !== 10'd44) begin bad++; $display("FAIL pool_p2 got=%b,%b,%0d want=1,0011,44", b_fire, b_act, b_y[19:10]); end
    keycode = '0; tick();
    tankdir = 2'b11; parentX = 10'd100; parentY = 10'd200; keycode = FIRE; tick();
    total++; if (b_fire !== 1'b1 || b_act !== 4'b0111) begin bad++; $display("FAIL pool_p3 got=%b,%b want=1,0111", b_fire, b_act); end
    keycode = '0; tick();
    keycode = FIRE; tick();
    total++; if (b_fire !== 1'b1 || b_act !== 4'b1111) begin bad++; $display("FAIL pool_p4 got=%b,%b want=1,1111", b_fire, b_act); end
    keycode = '0; tick();
    total++; if (b_y[19:10] !== 10'd4) begin bad++; $display("FAIL pool_slot1_y got=%0d want=4", b_y[19:10]); end
    keycode = FIRE; tick();
    total++; if (b_fire !== 1'b0 || b_act !== 4'b1101) begin bad++; $display("FAIL pool_p5_drop got=%b,%b want=0,1101", b_fire, b_act); end
    keycode = '0; tick();
    parentX = 10'd300; parentY = 10'd300; keycode = FIRE; tick();
    total++; if (b_fire !== 1'b1 || b_act !== 4'b1111) begin bad++; $display("FAIL pool_p6 got=%b,%b want=1,1111", b_fire, b_act); end
    total++; if (b_x[19:10] !== 10'd300 || b_y[19:10] !== 10'd300 || b_x[9:0] !== 10'd180) begin bad++; $display("FAIL pool_p6_pos got=%0d,%0d,%0d want=300,300,180", b_x[19:10], b_y[19:10], b_x[9:0]); end
    keycode = '0;
  endtask

  initial begin
    test_reset();
    test_launch_right();
    test_cooldown();
    test_retire_up();
    test_hit();
    test_reset_midflight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/projectile_pool.md
PROJECTILE_POOL -- requirements
Module: projectile_pool

Interface
REQ-001 Parameter NUM_SHOTS, default 4; number of independent projectile slots, range 1..8.
REQ-002 Parameter STEP, default 8; pixels moved per frame per axis, range 1..31.
REQ-003 Parameter COOLDOWN, default 6; frames after a launch before the next launch is accepted, range 0..63.
REQ-004 Parameter FIRE_CODE, default 16'h0009; keycode value meaning "fire".
REQ-005 Parameters X_MIN/X_MAX/Y_MIN/Y_MAX, defaults 1/639/1/479; playfield bounds, inclusive.
REQ-006 frame_clk  in  1  sole clock; one rising edge per video frame.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 keycode  in  16  current key code.
REQ-009 tankdir  in  2  firing tank heading: 00 up, 01 left, 10 down, 11 right.
REQ-010 parentX, parentY  in  10 each  firing tank centre.
REQ-011 otherX, otherY, tank_size  in  10 each  target tank centre and full edge length.
REQ-012 shot_x, shot_y  out  NUM_SHOTS*10 each  slot positions; slot i occupies bits [10*i+9:10*i].
REQ-013 shot_active  out  NUM_SHOTS  bit i high while slot i is in flight.
REQ-014 ball_fire  out  1  one-cycle pulse on each accepted launch.
REQ-015 hit  out  1  one-cycle pulse when any slot strikes the target.
REQ-016 hit_count  out  8  saturating count of hits since reset.

Function
REQ-017 The fire request SHALL be the rising edge of (keycode == FIRE_CODE), registered so holding the key yields exactly one request.
REQ-018 A request SHALL be accepted only when the cooldown counter is 0 and at least one slot is idle at the start of the cycle; otherwise it SHALL be dropped without queuing.
REQ-019 An accepted launch SHALL claim the lowest-index idle slot, load parentX/parentY and the tankdir heading, set shot_active[i], and pulse ball_fire in that same cycle.
REQ-020 A launched slot SHALL hold its launch position for the launch frame and advance by STEP along its heading on every later frame (up: y-STEP, left: x-STEP, down: y+STEP, right: x+STEP).
REQ-021 Each slot SHALL be a two-state FSM: IDLE -> FLY on launch; FLY -> IDLE on retire. IDLE slots SHALL output position 0.
REQ-022 A slot in FLY SHALL retire when its next position, computed in 11-bit signed arithmetic, falls outside [X_MIN,X_MAX] x [Y_MIN,Y_MAX]; the position SHALL never wrap.
REQ-023 A slot in FLY SHALL register a hit when its current position satisfies shot_x+tank_size/2 >= otherX, shot_x <= otherX+tank_size/2, and the same for y; all sums SHALL use 11 bits to avoid underflow.
REQ-024 A hit SHALL retire the slot, pulse hit the same cycle, and increment hit_count (saturating at 255); multiple simultaneous hits SHALL pulse hit once and increment hit_count by one.
REQ-025 When a hit and an out-of-bounds condition coincide, the hit SHALL take priority.
REQ-026 A slot launched in a given cycle SHALL NOT be checked for hit or bounds until the following frame.
REQ-027 A slot retiring in a cycle SHALL NOT be re-launched until the next cycle.
REQ-028 The cooldown counter SHALL load COOLDOWN on launch, decrement once per frame to 0, and never underflow.

Reset
REQ-029 On Reset every slot SHALL be IDLE with position 0; shot_active, ball_fire, hit, hit_count and cooldown SHALL be 0; the fire-edge register SHALL be cleared, so a key already held at reset release SHALL produce one request.

Structure
REQ-030 A shared package SHALL hold the heading enum (UP, LEFT, DOWN, RIGHT), the slot state enum (IDLE, FLY), and the 10-bit coordinate typedef.
REQ-031 Per-slot motion, bounds and hit logic SHALL live in sub-module projectile_slot, instantiated NUM_SHOTS times; allocation, cooldown and the hit/count reduction SHALL live in the top level.

Verification
REQ-032 Fire key held 5 frames, tankdir=11, parent (100,200) -> one ball_fire pulse; slot0 at (100,200), then (108,200), (116,200).
REQ-033 With COOLDOWN=6, fire pressed on frames 0, 3 and 7 -> launches on frames 0 and 7 only.
REQ-034 Launch with tankdir=00 from (50,20) -> y = 20, 12, 4, then retires (next y = -4), shot_active[0]=0 with no wrap.
REQ-035 Target (300,200), tank_size 20, shot fired right from (260,200) -> hit pulse when x=292; slot retires and hit_count=1.
REQ-036 NUM_SHOTS=4, COOLDOWN=0, five presses with all slots in flight -> slots 0-3 used, fifth press dropped; after slot 1 retires the next press takes slot 1.
REQ-037 Reset asserted mid-flight with two active shots -> next cycle all outputs 0; fire key held through release -> exactly one launch.
